// File: rtl/cellrv32_package.sv
`default_nettype none
// ============================================================================
//  Module   : cellrv32_package
//  Purpose  : Shared constants and types for the advanced PWM controller:
//             bus base/size, register offsets, CTRL bit positions, counter
//             direction and alignment-mode encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package cellrv32_package;

    // IO bus window of the PWM controller
    localparam logic [31:0] pwm_base_c      = 32'hFFFFF000;
    localparam int          pwm_size_c      = 128;
    localparam int          pwm_hi_abb_c    = 31;
    localparam int          pwm_lo_abb_c    = $clog2(pwm_size_c);

    localparam logic [31:0] pwm_ctrl_addr_c = pwm_base_c + 32'h00;
    localparam logic [31:0] pwm_top_addr_c  = pwm_base_c + 32'h04;
    localparam logic [31:0] pwm_ch0_addr_c  = pwm_base_c + 32'h08;

    // CTRL register bit positions
    localparam int pwm_ctrl_en_c       = 0;
    localparam int pwm_ctrl_prsc_lsb_c = 1;
    localparam int pwm_ctrl_prsc_msb_c = 3;
    localparam int pwm_ctrl_mode_c     = 4;
    localparam int pwm_ctrl_irq_en_c   = 5;
    localparam int pwm_ctrl_irq_pnd_c  = 31;

    // CHi register: polarity bit
    localparam int pwm_ch_pol_c        = 31;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_t;

endpackage
`default_nettype wire

// File: rtl/cellrv32_pwm_adv_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : cellrv32_pwm_adv_cnt
//  Purpose  : PWM period counter. Edge mode counts 0..TOP and wraps; center
//             mode counts 0..TOP..0. Holds the active TOP copy, reloaded from
//             the buffer at each period boundary or continuously while
//             disabled, and emits a one-cycle boundary strobe.
//  Ports    : clk_i, rstn_i (async, active-low)
//             i_enable   - counter running
//             i_mode     - 0 edge-aligned, 1 center-aligned
//             i_tick     - prescaler tick
//             i_top_buf  - buffered TOP value
//             o_cnt      - current counter value
//             o_boundary - period boundary strobe (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module cellrv32_pwm_adv_cnt
    import cellrv32_package::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 i_enable,
    input  logic                 i_mode,
    input  logic                 i_tick,
    input  logic [CNT_WIDTH-1:0] i_top_buf,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_boundary
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_top_act;
    pwm_dir_t             r_dir;
    logic                 w_boundary;

    always_comb begin
        w_boundary = 1'b0;
        if (i_enable && i_tick) begin
            if (r_top_act == '0) begin
                w_boundary = 1'b1;
            end else if (i_mode == MODE_EDGE) begin
                w_boundary = (r_cnt >= r_top_act);
            end else begin
                w_boundary = (r_dir == DIR_DOWN) && (r_cnt == '0);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt     <= '0;
            r_top_act <= '0;
            r_dir     <= DIR_UP;
        end else if (!i_enable) begin
            r_cnt     <= '0;
            r_dir     <= DIR_UP;
            r_top_act <= i_top_buf;
        end else if (i_tick) begin
            if (w_boundary) begin
                // New period: center mode has already spent the tick at 0,
                // so it resumes at 1 unless the new TOP pins the counter at 0.
                r_top_act <= i_top_buf;
                r_dir     <= DIR_UP;
                if ((i_mode == MODE_CENTER) && (i_top_buf != '0)) begin
                    r_cnt <= CNT_WIDTH'(1);
                end else begin
                    r_cnt <= '0;
                end
            end else if (i_mode == MODE_EDGE) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
                r_dir <= DIR_UP;
            end else if (r_dir == DIR_UP) begin
                if (r_cnt >= r_top_act) begin
                    r_dir <= DIR_DOWN;
                    r_cnt <= r_cnt - CNT_WIDTH'(1);
                end else begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end else begin
                r_cnt <= r_cnt - CNT_WIDTH'(1);
            end
        end
    end

    assign o_cnt      = r_cnt;
    assign o_boundary = w_boundary;

endmodule
`default_nettype wire

// File: rtl/cellrv32_pwm_adv.sv
`default_nettype none
// ============================================================================
//  Module   : cellrv32_pwm_adv
//  Purpose  : Advanced PWM controller on the processor IO bus. Programmable
//             TOP, edge/center alignment, per-channel polarity, and
//             double-buffered TOP/duty/polarity that update at period
//             boundaries (or every cycle while disabled).
//  Macro    : CELLRV32_PWM_IRQ_EN - enables the period-end interrupt
//             (CTRL.irq_en, CTRL.irq_pending, irq_o). Undefined: irq_o = 0.
//  Ports    : clk_i, rstn_i (async, active-low)
//             addr_i, rden_i, wren_i, data_i, data_o, ack_o - IO bus
//             clkgen_en_o - clock generator enable, clkgen_i - prescaler ticks
//             pwm_o - PWM outputs, irq_o - period-end interrupt
//  Revision : 1.0 - initial release
// ============================================================================
module cellrv32_pwm_adv
    import cellrv32_package::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [31:0]             addr_i,
    input  logic                    rden_i,
    input  logic                    wren_i,
    input  logic [31:0]             data_i,
    output logic [31:0]             data_o,
    output logic                    ack_o,
    output logic                    clkgen_en_o,
    input  logic [7:0]              clkgen_i,
    output logic [NUM_CHANNELS-1:0] pwm_o,
    output logic                    irq_o
);

    localparam logic [4:0] C_CTRL_OFFS = pwm_ctrl_addr_c[6:2];
    localparam logic [4:0] C_TOP_OFFS  = pwm_top_addr_c[6:2];
    localparam logic [4:0] C_CH0_OFFS  = pwm_ch0_addr_c[6:2];

    if ((NUM_CHANNELS < 1) || (NUM_CHANNELS > 16)) begin : g_chk_channels
        $error("cellrv32_pwm_adv: NUM_CHANNELS must be in 1..16");
    end
    if ((CNT_WIDTH < 8) || (CNT_WIDTH > 16)) begin : g_chk_width
        $error("cellrv32_pwm_adv: CNT_WIDTH must be in 8..16");
    end

    logic                 r_enable;
    logic [2:0]           r_prsc;
    logic                 r_mode;
    logic [CNT_WIDTH-1:0] r_top_buf;
    logic                 r_ack;
    logic [31:0]          r_data;

    logic                 w_acc_en;
    logic                 w_wr;
    logic                 w_rd;
    logic [4:0]           w_offset;
    logic [4:0]           w_ch_idx;
    logic                 w_ch_hit;
    logic [31:0]          w_rdata;
    logic                 w_tick;
    logic [CNT_WIDTH-1:0] w_cnt;
    logic                 w_boundary;
    logic                 w_irq_en_rd;
    logic                 w_irq_pnd_rd;
    logic [CNT_WIDTH-1:0] w_duty_rd [16];
    logic                 w_pol_rd  [16];
    logic                 w_unused_bits;

    // ---------------- bus decode ----------------
    assign w_acc_en = (addr_i[pwm_hi_abb_c:pwm_lo_abb_c] == pwm_base_c[pwm_hi_abb_c:pwm_lo_abb_c]);
    assign w_wr     = w_acc_en & wren_i;
    assign w_rd     = w_acc_en & rden_i;
    assign w_offset = addr_i[pwm_lo_abb_c-1:2];
    assign w_ch_idx = w_offset - C_CH0_OFFS;
    assign w_ch_hit = (w_offset >= C_CH0_OFFS) && (w_ch_idx < 5'd16);

    assign w_unused_bits = ^{addr_i[1:0], data_i[30:CNT_WIDTH]};

    // ---------------- control / TOP buffer ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_enable  <= 1'b0;
            r_prsc    <= '0;
            r_mode    <= 1'b0;
            r_top_buf <= '0;
        end else if (w_wr) begin
            if (w_offset == C_CTRL_OFFS) begin
                r_enable <= data_i[pwm_ctrl_en_c];
                r_prsc   <= data_i[pwm_ctrl_prsc_msb_c:pwm_ctrl_prsc_lsb_c];
                r_mode   <= data_i[pwm_ctrl_mode_c];
            end
            if (w_offset == C_TOP_OFFS) begin
                r_top_buf <= data_i[CNT_WIDTH-1:0];
            end
        end
    end

    assign clkgen_en_o = r_enable;
    assign w_tick      = clkgen_i[r_prsc];

    // ---------------- period counter ----------------
    cellrv32_pwm_adv_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .i_enable   (r_enable),
        .i_mode     (r_mode),
        .i_tick     (w_tick),
        .i_top_buf  (r_top_buf),
        .o_cnt      (w_cnt),
        .o_boundary (w_boundary)
    );

    // ---------------- channels ----------------
    // The readback arrays are always 16 deep; absent channels read as 0,
    // which keeps the read mux independent of NUM_CHANNELS.
    for (genvar i = 0; i < 16; i++) begin : g_ch
        if (i < NUM_CHANNELS) begin : g_present
            localparam logic [4:0] C_OFFS = C_CH0_OFFS + 5'(i);

            logic [CNT_WIDTH-1:0] r_duty_buf;
            logic [CNT_WIDTH-1:0] r_duty_act;
            logic                 r_pol_buf;
            logic                 r_pol_act;
            logic                 r_pwm;

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_duty_buf <= '0;
                    r_duty_act <= '0;
                    r_pol_buf  <= 1'b0;
                    r_pol_act  <= 1'b0;
                    r_pwm      <= 1'b0;
                end else begin
                    if (w_wr && (w_offset == C_OFFS)) begin
                        r_duty_buf <= data_i[CNT_WIDTH-1:0];
                        r_pol_buf  <= data_i[pwm_ch_pol_c];
                    end
                    // Active copy samples the buffer before any same-cycle
                    // write lands, so a write at a boundary waits one period.
                    if (!r_enable || w_boundary) begin
                        r_duty_act <= r_duty_buf;
                        r_pol_act  <= r_pol_buf;
                    end
                    if (r_enable) begin
                        r_pwm <= (w_cnt < r_duty_act) ^ r_pol_act;
                    end else begin
                        r_pwm <= r_pol_buf;
                    end
                end
            end

            assign w_duty_rd[i] = r_duty_buf;
            assign w_pol_rd[i]  = r_pol_buf;
            assign pwm_o[i]     = r_pwm;
        end else begin : g_absent
            assign w_duty_rd[i] = '0;
            assign w_pol_rd[i]  = 1'b0;
        end
    end

    // ---------------- interrupt ----------------
`ifdef CELLRV32_PWM_IRQ_EN
    logic r_irq_en;
    logic r_irq_pnd;
    logic r_irq;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_irq_en  <= 1'b0;
            r_irq_pnd <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr && (w_offset == C_CTRL_OFFS)) begin
                r_irq_en <= data_i[pwm_ctrl_irq_en_c];
            end
            // A boundary beats a simultaneous clear request.
            if (w_boundary) begin
                r_irq_pnd <= 1'b1;
            end else if (w_wr && (w_offset == C_CTRL_OFFS) && data_i[pwm_ctrl_irq_pnd_c]) begin
                r_irq_pnd <= 1'b0;
            end
            r_irq <= r_irq_pnd & r_irq_en;
        end
    end

    assign irq_o        = r_irq;
    assign w_irq_en_rd  = r_irq_en;
    assign w_irq_pnd_rd = r_irq_pnd;
`else
    assign irq_o        = 1'b0;
    assign w_irq_en_rd  = 1'b0;
    assign w_irq_pnd_rd = 1'b0;
`endif

    // ---------------- read mux ----------------
    always_comb begin
        w_rdata = '0;
        if (w_offset == C_CTRL_OFFS) begin
            w_rdata[pwm_ctrl_en_c]                           = r_enable;
            w_rdata[pwm_ctrl_prsc_msb_c:pwm_ctrl_prsc_lsb_c] = r_prsc;
            w_rdata[pwm_ctrl_mode_c]                         = r_mode;
            w_rdata[pwm_ctrl_irq_en_c]                       = w_irq_en_rd;
            w_rdata[pwm_ctrl_irq_pnd_c]                      = w_irq_pnd_rd;
        end else if (w_offset == C_TOP_OFFS) begin
            w_rdata[CNT_WIDTH-1:0] = r_top_buf;
        end else if (w_ch_hit) begin
            w_rdata[CNT_WIDTH-1:0] = w_duty_rd[w_ch_idx[3:0]];
            w_rdata[pwm_ch_pol_c]  = w_pol_rd[w_ch_idx[3:0]];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ack  <= 1'b0;
            r_data <= '0;
        end else begin
            r_ack  <= w_wr | w_rd;
            r_data <= w_rd ? w_rdata : 32'h0;
        end
    end

    assign ack_o  = r_ack;
    assign data_o = r_data;

endmodule
`default_nettype wire
